// File: rtl/seg_scan_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | seg_scan_if : data/control and pin bundle for the seg_scan_driver block      |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
interface seg_scan_if #(
    parameter int N_DIGITS = 8
);
    logic [4*N_DIGITS-1:0] DI;
    logic [N_DIGITS-1:0]   DP_MASK;
    logic [N_DIGITS-1:0]   BLANK;
    logic                  HEX_EN;
    logic                  LZ_EN;
    logic                  LOAD;
    logic [6:0]            SEG;
    logic                  DP;
    logic [N_DIGITS-1:0]   AN;
    logic                  FRAME;

    modport master (
        output DI, DP_MASK, BLANK, HEX_EN, LZ_EN, LOAD,
        input  SEG, DP, AN, FRAME
    );

    modport slave (
        input  DI, DP_MASK, BLANK, HEX_EN, LZ_EN, LOAD,
        output SEG, DP, AN, FRAME
    );
endinterface

`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | seg_scan_driver : multiplexed common-anode 7-segment scanner, frame-buffered |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module seg_scan_driver #(
    parameter int N_DIGITS = 8,
    parameter int DIV      = 200000,
    parameter int DEAD     = 0
) (
    input  logic       CLK,
    input  logic       RST,
    seg_scan_if.slave  bus
);
    localparam int c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_DIGITS - 1);

    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_IDX_W-1:0]      r_idx;
    logic                    r_run;
    logic                    r_frame;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [N_DIGITS-1:0]     r_an;
    logic [4*N_DIGITS-1:0]   r_pend_di;
    logic [N_DIGITS-1:0]     r_pend_dp;
    logic [N_DIGITS-1:0]     r_pend_blank;
    logic                    r_pend_vld;
    logic [4*N_DIGITS-1:0]   r_shd_di;
    logic [N_DIGITS-1:0]     r_shd_dp;
    logic [N_DIGITS-1:0]     r_shd_blank;

    logic                    w_tick;
    logic                    w_wrap;
    logic                    w_lit;
    logic                    w_acc;
    logic [N_DIGITS-1:0]     w_zero_from;
    logic [N_DIGITS-1:0]     w_an_sel;
    logic [3:0]              w_nib;
    logic                    w_blank;
    logic                    w_dpm;
    logic                    w_lz;
    logic [6:0]              w_seg;
    logic                    w_dp;
    logic [N_DIGITS-1:0]     w_an;

    function automatic logic [6:0] f_decode(input logic [3:0] nib, input logic hex);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        if (!hex && nib > 4'h9) begin
            seg = 7'b1111111;
        end
        return seg;
    endfunction

    assign w_tick = (r_cnt == c_CNT_LAST);
    assign w_wrap = w_tick && (r_idx == c_IDX_LAST);

    // Anode stays off for the first DEAD cycles of every slot to avoid ghosting.
    generate
        if (DEAD == 0) begin : g_no_dead
            assign w_lit = 1'b1;
        end else begin : g_dead
            assign w_lit = (r_cnt >= c_CNT_W'(DEAD));
        end
    endgenerate

    always_comb begin
        w_zero_from = '0;
        w_acc       = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            w_acc          = w_acc && (r_shd_di[4*i +: 4] == 4'h0);
            w_zero_from[i] = w_acc;
        end
    end

    always_comb begin
        w_nib    = 4'h0;
        w_blank  = 1'b0;
        w_dpm    = 1'b0;
        w_lz     = 1'b0;
        w_an_sel = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_nib       = r_shd_di[4*i +: 4];
                w_blank     = r_shd_blank[i];
                w_dpm       = r_shd_dp[i];
                w_lz        = (i != 0) && w_zero_from[i];
                w_an_sel[i] = 1'b0;
            end
        end
    end

    always_comb begin
        w_seg = 7'h7F;
        w_dp  = 1'b1;
        w_an  = '1;
        if (r_run) begin
            if (w_lit) begin
                w_an = w_an_sel;
            end
            if (!w_blank) begin
                w_dp = ~w_dpm;
                if (!(bus.LZ_EN && w_lz)) begin
                    w_seg = f_decode(w_nib, bus.HEX_EN);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_run        <= 1'b0;
            r_frame      <= 1'b0;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_an         <= '1;
            r_pend_di    <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_vld   <= 1'b0;
            r_shd_di     <= '0;
            r_shd_dp     <= '0;
            r_shd_blank  <= '0;
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
            r_frame <= w_wrap;
            if (w_tick) begin
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end
            if (w_wrap) begin
                r_run <= 1'b1;
            end
            // A LOAD landing on the wrap bypasses the pending stage entirely.
            if (w_wrap) begin
                if (bus.LOAD) begin
                    r_shd_di    <= bus.DI;
                    r_shd_dp    <= bus.DP_MASK;
                    r_shd_blank <= bus.BLANK;
                end else if (r_pend_vld) begin
                    r_shd_di    <= r_pend_di;
                    r_shd_dp    <= r_pend_dp;
                    r_shd_blank <= r_pend_blank;
                end
                r_pend_vld <= 1'b0;
            end else if (bus.LOAD) begin
                r_pend_di    <= bus.DI;
                r_pend_dp    <= bus.DP_MASK;
                r_pend_blank <= bus.BLANK;
                r_pend_vld   <= 1'b1;
            end
            r_seg <= w_seg;
            r_dp  <= w_dp;
            r_an  <= w_an;
        end
    end

    assign bus.SEG   = r_seg;
    assign bus.DP    = r_dp;
    assign bus.AN    = r_an;
    assign bus.FRAME = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_seg_scan_driver : directed, table-driven bench for seg_scan_driver        |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module tb_seg_scan_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    seg_scan_if #(.N_DIGITS(4)) bus ();
    seg_scan_if #(.N_DIGITS(4)) bus2 ();

    seg_scan_driver #(.N_DIGITS(4), .DIV(4), .DEAD(0)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    seg_scan_driver #(.N_DIGITS(4), .DIV(4), .DEAD(2)) dut_dead (
        .CLK (clk),
        .RST (rst),
        .bus (bus2.slave)
    );

    assign bus2.DI      = bus.DI;
    assign bus2.DP_MASK = bus.DP_MASK;
    assign bus2.BLANK   = bus.BLANK;
    assign bus2.HEX_EN  = bus.HEX_EN;
    assign bus2.LZ_EN   = bus.LZ_EN;
    assign bus2.LOAD    = bus.LOAD;

    typedef struct {
        logic [15:0]      di;
        logic [3:0]       dpm;
        logic [3:0]       blank;
        logic             hex;
        logic             lz;
        logic [3:0][6:0]  seg;   // {digit3, digit2, digit1, digit0}
        logic [3:0]       dp;
    } vec_t;

    vec_t       tbl [9];
    logic [6:0] got_seg [4];
    logic       got_dp  [4];
    logic [3:0] got_an  [4];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(input string name);
        for (int n = 0; n < 64; n++) begin
            step(1);
            if (bus.FRAME === 1'b1) return;
        end
        n_checks++;
        n_err++;
        $display("FAIL %s frame_timeout got=none exp=FRAME within 64 cycles", name);
    endtask

    task automatic load(input logic [15:0] di, input logic [3:0] dpm, input logic [3:0] blank);
        bus.DI      = di;
        bus.DP_MASK = dpm;
        bus.BLANK   = blank;
        bus.LOAD    = 1'b1;
        step(1);
        bus.LOAD    = 1'b0;
    endtask

    // Called just after a FRAME edge; samples the middle of each digit slot.
    task automatic capture();
        for (int k = 0; k < 4; k++) begin
            step((k == 0) ? 2 : 4);
            got_seg[k] = bus.SEG;
            got_dp[k]  = bus.DP;
            got_an[k]  = bus.AN;
        end
    endtask

    task automatic check_frame(input string name, input logic [3:0][6:0] seg, input logic [3:0] dp);
        logic [3:0] an_exp;
        for (int k = 0; k < 4; k++) begin
            an_exp = ~(4'b0001 << k);
            chk($sformatf("%s_d%0d_an",  name, k), {28'b0, got_an[k]}, {28'b0, an_exp});
            chk($sformatf("%s_d%0d_seg", name, k), {25'b0, got_seg[k]}, {25'b0, seg[k]});
            chk($sformatf("%s_d%0d_dp",  name, k), {31'b0, got_dp[k]}, {31'b0, dp[k]});
        end
    endtask

    initial begin
        int   n;
        logic an_seen;

        tbl[0] = '{16'h1234, 4'b0000, 4'b0000, 1'b1, 1'b0,
                   {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111};
        tbl[1] = '{16'h00A0, 4'b0000, 4'b0000, 1'b1, 1'b1,
                   {7'b1111111, 7'b1111111, 7'b0001000, 7'b1000000}, 4'b1111};
        tbl[2] = '{16'h00A0, 4'b0000, 4'b0000, 1'b0, 1'b1,
                   {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111};
        tbl[3] = '{16'h0000, 4'b0100, 4'b0000, 1'b1, 1'b1,
                   {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1011};
        tbl[4] = '{16'h1234, 4'b0001, 4'b0001, 1'b1, 1'b0,
                   {7'b1111001, 7'b0100100, 7'b0110000, 7'b1111111}, 4'b1111};
        tbl[5] = '{16'h9BCD, 4'b0000, 4'b0000, 1'b1, 1'b0,
                   {7'b0010000, 7'b0000011, 7'b1000110, 7'b0100001}, 4'b1111};
        tbl[6] = '{16'hEF00, 4'b0000, 4'b0000, 1'b1, 1'b1,
                   {7'b0000110, 7'b0001110, 7'b1000000, 7'b1000000}, 4'b1111};
        tbl[7] = '{16'h0F00, 4'b0000, 4'b0000, 1'b0, 1'b1,
                   {7'b1111111, 7'b1111111, 7'b1000000, 7'b1000000}, 4'b1111};
        tbl[8] = '{16'h1230, 4'b1010, 4'b1000, 1'b1, 1'b1,
                   {7'b1111111, 7'b0100100, 7'b0110000, 7'b1000000}, 4'b1101};

        bus.DI      = '0;
        bus.DP_MASK = '0;
        bus.BLANK   = '0;
        bus.HEX_EN  = 1'b1;
        bus.LZ_EN   = 1'b0;
        bus.LOAD    = 1'b0;

        // Reset values
        step(3);
        chk("rst_seg",   {25'b0, bus.SEG}, 32'h7F);
        chk("rst_dp",    {31'b0, bus.DP},  32'h1);
        chk("rst_an",    {28'b0, bus.AN},  32'hF);
        chk("rst_frame", {31'b0, bus.FRAME}, 32'h0);
        chk("rst_an_dead", {28'b0, bus2.AN}, 32'hF);
        rst = 1'b0;

        // First wrap lands 16 cycles after reset release; anodes stay off until then
        n = 0;
        an_seen = 1'b0;
        while (n < 40) begin
            step(1);
            n++;
            if (bus.FRAME === 1'b1) break;
            if (bus.AN !== 4'hF) an_seen = 1'b1;
        end
        chk("first_frame_cycles", n, 16);
        chk("pre_wrap_an_off", {31'b0, an_seen}, 32'h0);

        // Dead-time instance: two dark cycles then two lit cycles per slot
        step(1);
        chk("d0_an",        {28'b0, bus.AN},   32'hE);
        chk("d0_seg_zero",  {25'b0, bus.SEG},  32'h40);
        chk("dead_c0_an",   {28'b0, bus2.AN},  32'hF);
        chk("dead_c0_seg",  {25'b0, bus2.SEG}, 32'h40);
        step(1);
        chk("dead_c1_an",   {28'b0, bus2.AN},  32'hF);
        step(1);
        chk("dead_c2_an",   {28'b0, bus2.AN},  32'hE);
        step(1);
        chk("dead_c3_an",   {28'b0, bus2.AN},  32'hE);
        step(1);
        chk("dead_next_an", {28'b0, bus2.AN},  32'hF);

        // Mid-frame LOAD must not tear the current frame
        load(16'h5678, 4'b0000, 4'b0000);
        step(8);
        chk("midload_d3_an",  {28'b0, bus.AN},  32'h7);
        chk("midload_d3_seg", {25'b0, bus.SEG}, 32'h40);
        wait_frame("midload");
        capture();
        check_frame("midload_new", {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}, 4'b1111);

        for (int v = 0; v < 9; v++) begin
            bus.HEX_EN = tbl[v].hex;
            bus.LZ_EN  = tbl[v].lz;
            load(tbl[v].di, tbl[v].dpm, tbl[v].blank);
            wait_frame($sformatf("vec%0d", v));
            capture();
            check_frame($sformatf("vec%0d", v), tbl[v].seg, tbl[v].dp);
        end

        // Several LOADs in one frame: the last one is shown
        bus.HEX_EN = 1'b1;
        bus.LZ_EN  = 1'b0;
        load(16'h1111, 4'b0000, 4'b0000);
        load(16'h2222, 4'b0000, 4'b0000);
        wait_frame("lastwins");
        capture();
        check_frame("lastwins", {7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100}, 4'b1111);

        // LOAD coincident with the wrap tick is visible on the very next digit 0
        wait_frame("tickload");
        step(15);
        bus.DI   = 16'h0009;
        bus.LOAD = 1'b1;
        step(1);
        bus.LOAD = 1'b0;
        chk("tickload_frame", {31'b0, bus.FRAME}, 32'h1);
        step(1);
        chk("tickload_an",  {28'b0, bus.AN},  32'hE);
        chk("tickload_seg", {25'b0, bus.SEG}, 32'h10);

        // Reset mid-frame discards a pending LOAD
        step(3);
        load(16'h3333, 4'b0000, 4'b0000);
        rst = 1'b1;
        step(1);
        chk("midrst_an",    {28'b0, bus.AN},    32'hF);
        chk("midrst_frame", {31'b0, bus.FRAME}, 32'h0);
        chk("midrst_seg",   {25'b0, bus.SEG},   32'h7F);
        chk("midrst_dp",    {31'b0, bus.DP},    32'h1);
        rst = 1'b0;
        wait_frame("midrst");
        capture();
        check_frame("midrst_shadow", {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1111);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
